// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR peripheral: FSM states,
// register offsets, CTRL bit positions and the default polynomial.
package misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_e;

    // Byte offsets relative to the peripheral base address
    localparam logic [7:0] CTRL_OFF   = 8'h00;
    localparam logic [7:0] SEED_OFF   = 8'h04;
    localparam logic [7:0] POLY_OFF   = 8'h08;
    localparam logic [7:0] DIN_OFF    = 8'h0C;
    localparam logic [7:0] SIG_OFF    = 8'h10;
    localparam logic [7:0] COUNT_OFF  = 8'h14;
    localparam logic [7:0] TARGET_OFF = 8'h18;
    localparam logic [7:0] STATUS_OFF = 8'h1C;

    // First unmapped offset; everything at or above it raises err
    localparam logic [7:0] MAP_LIMIT  = 8'h20;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_STREAM_BIT = 2;

    // CRC-32 polynomial loaded into POLY at reset
    localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;

    // CTRL read-back image; CLR is self-clearing so it always reads 0
    function automatic logic [31:0] pack_ctrl(input logic en, input logic stream);
        logic [31:0] word;
        word = '0;
        word[CTRL_EN_BIT]     = en;
        word[CTRL_STREAM_BIT] = stream;
        return word;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register and single-step MISR update. A seed load takes
// priority over a step issued in the same cycle.
module misr_core
    import misr_pkg::*;
#(
    parameter int NBIT_MISR_DATA = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      step_i,
    input  logic [NBIT_MISR_DATA-1:0] din_i,
    input  logic                      load_seed_i,
    input  logic [NBIT_MISR_DATA-1:0] seed_i,
    input  logic [NBIT_MISR_DATA-1:0] poly_i,
    output logic [NBIT_MISR_DATA-1:0] sig_o
);

    logic [NBIT_MISR_DATA-1:0] sig_reg;
    logic [NBIT_MISR_DATA-1:0] sig_next;
    logic [NBIT_MISR_DATA-1:0] shifted;
    logic [NBIT_MISR_DATA-1:0] feedback;

    // Left shift by one with a zero entering the LSB
    for (genvar gi = 0; gi < NBIT_MISR_DATA; gi++) begin : g_shift
        if (gi == 0) begin : g_lsb
            assign shifted[gi] = 1'b0;
        end else begin : g_upper
            assign shifted[gi] = sig_reg[gi-1];
        end
    end

    // Polynomial is folded back in whenever the bit shifted out is set
    for (genvar gi = 0; gi < NBIT_MISR_DATA; gi++) begin : g_fb
        assign feedback[gi] = sig_reg[NBIT_MISR_DATA-1] & poly_i[gi];
    end

    assign sig_next = shifted ^ feedback ^ din_i;
    assign sig_o    = sig_reg;

    // Signature register: seed load wins over a step
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_reg <= '0;
        end else if (load_seed_i) begin
            sig_reg <= seed_i;
        end else if (step_i) begin
            sig_reg <= sig_next;
        end
    end

endmodule

// File: rtl/misr_periph.sv
// Memory-mapped MISR peripheral: register file, IDLE/RUN/DONE control
// FSM, bus/stream step arbitration and registered read port.
module misr_periph
    import misr_pkg::*;
#(
    parameter int NBIT_MISR_DATA = 32,
    parameter int NBIT_MISR_ADDR = 32,
    parameter logic [NBIT_MISR_ADDR-1:0] MISR_PERIPH_START_ADDR = NBIT_MISR_ADDR'(2**25)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      re_i,
    input  logic                      we_i,
    input  logic [NBIT_MISR_ADDR-1:0] addr_i,
    input  logic [NBIT_MISR_DATA-1:0] data_i,
    output logic [NBIT_MISR_DATA-1:0] rdata_o,
    output logic                      rvalid_o,
    output logic                      err_o,
    input  logic                      stream_valid_i,
    input  logic [NBIT_MISR_DATA-1:0] stream_data_i,
    output logic                      stream_ready_o,
    output logic                      done_o
);

    misr_state_e state_reg;
    misr_state_e state_next;

    logic                      en_reg;
    logic                      stream_reg;
    logic [NBIT_MISR_DATA-1:0] seed_reg;
    logic [NBIT_MISR_DATA-1:0] poly_reg;
    logic [NBIT_MISR_DATA-1:0] target_reg;
    logic [NBIT_MISR_DATA-1:0] count_reg;
    logic [NBIT_MISR_DATA-1:0] count_inc;
    logic [NBIT_MISR_DATA-1:0] sig;

    logic [NBIT_MISR_DATA-1:0] rdata_reg;
    logic [NBIT_MISR_DATA-1:0] rdata_next;
    logic                      rvalid_reg;
    logic                      err_reg;

    logic [NBIT_MISR_ADDR-1:0] offset;
    logic [5:0]                word;
    logic                      mapped;
    logic                      ctrl_wr;
    logic                      seed_wr;
    logic                      poly_wr;
    logic                      target_wr;
    logic                      din_hit;
    logic                      clr;
    logic                      running;
    logic                      stream_ready;
    logic                      stream_fire;
    logic                      step;
    logic [NBIT_MISR_DATA-1:0] step_data;

    // Address decode relative to the base; low two offset bits are ignored
    assign offset    = addr_i - MISR_PERIPH_START_ADDR;
    assign word      = offset[7:2];
    assign mapped    = offset < {{(NBIT_MISR_ADDR-8){1'b0}}, MAP_LIMIT};
    assign ctrl_wr   = we_i & mapped & (word == CTRL_OFF[7:2]);
    assign seed_wr   = we_i & mapped & (word == SEED_OFF[7:2]);
    assign poly_wr   = we_i & mapped & (word == POLY_OFF[7:2]);
    assign target_wr = we_i & mapped & (word == TARGET_OFF[7:2]);
    assign din_hit   = we_i & mapped & (word == DIN_OFF[7:2]);
    assign clr       = ctrl_wr & data_i[CTRL_CLR_BIT];

    // A bus DIN write owns the step slot; the stream source holds its word
    assign running      = (state_reg == ST_RUN);
    assign stream_ready = running & stream_reg & ~din_hit;
    assign stream_fire  = stream_valid_i & stream_ready;
    assign step         = running & (din_hit | stream_fire);
    assign step_data    = din_hit ? data_i : stream_data_i;
    assign count_inc    = (count_reg == '1) ? count_reg : count_reg + 1'b1;

    assign stream_ready_o = stream_ready;
    assign done_o         = (state_reg == ST_DONE);
    assign rdata_o        = rdata_reg;
    assign rvalid_o       = rvalid_reg;
    assign err_o          = err_reg;

    misr_core #(
        .NBIT_MISR_DATA(NBIT_MISR_DATA)
    ) u_core (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .step_i     (step),
        .din_i      (step_data),
        .load_seed_i(clr),
        .seed_i     (seed_reg),
        .poly_i     (poly_reg),
        .sig_o      (sig)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: CLR overrides every other transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ctrl_wr && data_i[CTRL_EN_BIT]) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ctrl_wr && !data_i[CTRL_EN_BIT]) begin
                    state_next = ST_IDLE;
                end else if (step && (target_reg != '0) && (count_inc == target_reg)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ctrl_wr && !data_i[CTRL_EN_BIT]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (clr) begin
            state_next = ST_IDLE;
        end
    end

    // Software-visible configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_reg     <= 1'b0;
            stream_reg <= 1'b0;
            seed_reg   <= '0;
            poly_reg   <= NBIT_MISR_DATA'(DEFAULT_POLY);
            target_reg <= '0;
        end else begin
            if (ctrl_wr) begin
                en_reg     <= data_i[CTRL_EN_BIT];
                stream_reg <= data_i[CTRL_STREAM_BIT];
            end
            if (seed_wr) begin
                seed_reg <= data_i;
            end
            if (poly_wr) begin
                poly_reg <= data_i;
            end
            if (target_wr) begin
                target_reg <= data_i;
            end
        end
    end

    // Step counter, saturating, cleared by CLR
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (step) begin
            count_reg <= count_inc;
        end
    end

    // Read mux; DIN and unmapped offsets read as zero
    always_comb begin
        rdata_next = '0;
        if (mapped) begin
            case (word)
                CTRL_OFF[7:2]:   rdata_next = NBIT_MISR_DATA'(pack_ctrl(en_reg, stream_reg));
                SEED_OFF[7:2]:   rdata_next = seed_reg;
                POLY_OFF[7:2]:   rdata_next = poly_reg;
                SIG_OFF[7:2]:    rdata_next = sig;
                COUNT_OFF[7:2]:  rdata_next = count_reg;
                TARGET_OFF[7:2]: rdata_next = target_reg;
                STATUS_OFF[7:2]: rdata_next = {{(NBIT_MISR_DATA-2){1'b0}}, state_reg};
                default:         rdata_next = '0;
            endcase
        end
    end

    // Registered read response and error pulse; a write wins over a read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= re_i & ~we_i;
            if (re_i && !we_i) begin
                rdata_reg <= rdata_next;
            end
            err_reg <= (re_i | we_i) & ~mapped;
        end
    end

endmodule

// File: tb/tb_misr_periph.sv
// Self-checking bench for misr_periph: directed scenarios followed by
// randomized traffic, all checked against a register-level model.
module tb_misr_periph;

    localparam logic [31:0] BASE     = 32'h0200_0000;
    localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        re_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        err_o;
    logic        stream_valid_i = 1'b0;
    logic [31:0] stream_data_i = '0;
    logic        stream_ready_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;

    // Reference model state (state: 0 idle, 1 run, 2 done)
    logic [31:0] m_seed, m_poly, m_sig, m_count, m_target;
    int          m_state;
    bit          m_en, m_stream;

    misr_periph dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .re_i          (re_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .err_o         (err_o),
        .stream_valid_i(stream_valid_i),
        .stream_data_i (stream_data_i),
        .stream_ready_o(stream_ready_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    function automatic void model_reset();
        m_seed = '0; m_poly = DEF_POLY; m_sig = '0; m_count = '0; m_target = '0;
        m_state = 0; m_en = 0; m_stream = 0;
    endfunction

    // One signature step expressed as plain arithmetic on the word value
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] p,
                                             input logic [31:0] d);
        logic [31:0] fb;
        fb = (s >= 32'h8000_0000) ? p : 32'h0;
        return (s * 2) ^ fb ^ d;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return {29'd0, m_stream, 1'b0, m_en};
            1: return m_seed;
            2: return m_poly;
            4: return m_sig;
            5: return m_count;
            6: return m_target;
            7: return 32'(m_state);
            default: return 32'h0;
        endcase
    endfunction

    // One bus/stream clock cycle: drive, predict, clock, compare
    task automatic cycle(input bit we, input bit re, input logic [31:0] addr,
                         input logic [31:0] data, input bit sv, input logic [31:0] sd);
        logic [31:0] off, exp_rdata, din;
        bit          mapped, din_hit, exp_ready, exp_rvalid, exp_err, stepped;
        int          idx, nstate;
        off    = addr - BASE;
        mapped = (off < 32'd32);
        idx    = int'(off[4:2]);
        we_i = we; re_i = re; addr_i = addr; data_i = data;
        stream_valid_i = sv; stream_data_i = sd;
        #2;
        din_hit   = we && mapped && (idx == 3);
        exp_ready = (m_state == 1) && m_stream && !din_hit;
        chk("stream_ready", 32'(stream_ready_o), 32'(exp_ready));
        if (sv && stream_ready_o) hs_count++;
        exp_rvalid = re && !we;
        exp_rdata  = mapped ? model_read(idx) : 32'h0;
        exp_err    = (we || re) && !mapped;
        stepped = 0;
        din     = '0;
        nstate  = m_state;
        if (m_state == 1) begin
            if (din_hit) begin
                din = data; stepped = 1;
            end else if (sv && exp_ready) begin
                din = sd; stepped = 1;
            end
        end
        if (stepped) begin
            m_sig = ref_step(m_sig, m_poly, din);
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (m_target != 0 && m_count == m_target) nstate = 2;
        end
        if (we && mapped) begin
            case (idx)
                0: begin
                    m_en = data[0]; m_stream = data[2];
                    if (data[1]) begin
                        m_sig = m_seed; m_count = 0; nstate = 0;
                    end else if (data[0] && m_state == 0) begin
                        nstate = 1;
                    end else if (!data[0] && m_state != 0) begin
                        nstate = 0;
                    end
                end
                1: m_seed = data;
                2: m_poly = data;
                6: m_target = data;
                default: ;
            endcase
        end
        m_state = nstate;
        @(posedge clk_i);
        #1;
        chk("rvalid", 32'(rvalid_o), 32'(exp_rvalid));
        if (exp_rvalid) chk("rdata", rdata_o, exp_rdata);
        chk("err", 32'(err_o), 32'(exp_err));
        chk("done", 32'(done_o), 32'(m_state == 2));
        if (we || re)
            $display("txn we=%0d re=%0d off=0x%08h data=0x%08h rdata=0x%08h err=%0d",
                     we, re, off, data, rdata_o, err_o);
        we_i = 0; re_i = 0; stream_valid_i = 0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        cycle(1, 0, BASE + 32'(off), data, 0, 32'h0);
    endtask

    task automatic rd_const(input string tag, input logic [7:0] off, input logic [31:0] exp);
        cycle(0, 1, BASE + 32'(off), 32'h0, 0, 32'h0);
        chk(tag, rdata_o, exp);
    endtask

    initial begin
        logic [31:0] rnd, sd_hold;
        model_reset();
        // Outputs while reset is held
        #3;
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_ready", 32'(stream_ready_o), 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        rd_const("poly_reset", 8'h08, DEF_POLY);
        rd_const("sig_reset", 8'h10, 32'h0);

        // Basic stepping from zero seed
        wr(8'h04, 32'h0);
        wr(8'h00, 32'h2);
        wr(8'h00, 32'h1);
        wr(8'h0C, 32'h1);
        rd_const("sig_step1", 8'h10, 32'h1);
        rd_const("count_step1", 8'h14, 32'h1);
        wr(8'h0C, 32'h0);
        rd_const("sig_step2", 8'h10, 32'h2);
        rd_const("count_step2", 8'h14, 32'h2);

        // MSB feedback path
        wr(8'h04, 32'h8000_0000);
        wr(8'h00, 32'h2);
        wr(8'h00, 32'h1);
        wr(8'h0C, 32'h0);
        rd_const("sig_feedback", 8'h10, DEF_POLY);

        // Streaming to TARGET
        wr(8'h18, 32'd3);
        wr(8'h00, 32'h2);
        wr(8'h00, 32'h5);
        hs_count = 0;
        for (int i = 0; i < 5; i++) cycle(0, 0, BASE, 32'h0, 1, $urandom);
        chk("stream_handshakes", 32'(hs_count), 32'd3);
        chk("done_level", 32'(done_o), 32'h1);
        rd_const("status_done", 8'h1C, 32'h2);
        wr(8'h00, 32'h2);
        chk("done_after_clr", 32'(done_o), 32'h0);
        rd_const("sig_after_clr", 8'h10, 32'h8000_0000);
        rd_const("count_after_clr", 8'h14, 32'h0);

        // Bus DIN collides with a stream word
        wr(8'h18, 32'h0);
        wr(8'h00, 32'h5);
        sd_hold = $urandom;
        cycle(1, 0, BASE + 32'h0C, $urandom, 1, sd_hold);
        cycle(0, 0, BASE, 32'h0, 1, sd_hold);
        rd_const("count_collide", 8'h14, 32'h2);
        rd_const("sig_collide", 8'h10, m_sig);

        // Unmapped accesses
        cycle(0, 1, BASE + 32'h40, 32'h0, 0, 32'h0);
        chk("unmapped_rdata", rdata_o, 32'h0);
        chk("unmapped_err", 32'(err_o), 32'h1);
        cycle(1, 0, BASE + 32'h40, 32'hFFFF_FFFF, 0, 32'h0);
        rd_const("status_unmapped", 8'h1C, 32'h1);
        rd_const("count_unmapped", 8'h14, 32'h2);

        // Asynchronous reset in the middle of RUN
        rd_const("sig_before_rst", 8'h10, m_sig);
        stream_valid_i = 1'b1;
        #1;
        chk("ready_before_rst", 32'(stream_ready_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_ready", 32'(stream_ready_o), 32'h0);
        chk("midrst_rdata", rdata_o, 32'h0);
        chk("midrst_rvalid", 32'(rvalid_o), 32'h0);
        chk("midrst_done", 32'(done_o), 32'h0);
        model_reset();
        stream_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        rd_const("status_after_rst", 8'h1C, 32'h0);
        rd_const("poly_after_rst", 8'h08, DEF_POLY);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            case ($urandom_range(0, 11))
                0, 1, 2: cycle(1, 0, BASE + 32'h0C + 32'($urandom_range(0, 3)), rnd, $urandom_range(0, 1), $urandom);
                3, 4:    cycle(0, 0, BASE, 32'h0, $urandom_range(0, 1), rnd);
                5, 6:    cycle(0, 1, BASE + 32'($urandom_range(0, 47)), 32'h0, $urandom_range(0, 1), rnd);
                7:       cycle(1, 0, BASE, {29'd0, rnd[2], ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0)}, 0, 32'h0);
                8:       cycle(1, 0, BASE + 32'h18, 32'($urandom_range(0, 30)), 0, 32'h0);
                9:       cycle(1, 0, BASE + 32'($urandom_range(1, 2) * 4), rnd, 0, 32'h0);
                10:      cycle(1, 1, BASE + 32'($urandom_range(0, 40)), rnd, 0, 32'h0);
                default: cycle(1, 0, BASE, {29'd0, 1'b1, 1'b0, 1'b1}, 0, 32'h0);
            endcase
        end
        rd_const("final_sig", 8'h10, m_sig);
        rd_const("final_count", 8'h14, m_count);
        rd_const("final_status", 8'h1C, 32'(m_state));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
